// File: rtl/pulse_width_meter_pkg.sv
// Shared types and helpers for the pulse width meter.
package pulse_width_meter_pkg;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        WaitRise = 2'd0,
        MeasHigh = 2'd1,
        MeasLow  = 2'd2
    } meter_state_t;

    // Width of the idle timer so it can hold the full timeout value.
    function automatic int unsigned idle_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/pulse_width_meter_edge_detect.sv
// Rise/fall detector for a signal already synchronous to clk.
// Provides combinational edge flags and registered 1-cycle edge pulses.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic din_q;

    assign rise = din & ~din_q;
    assign fall = ~din & din_q;

    // Previous sample resets high so a line already high at release is not a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q      <= 1'b1;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            din_q      <= din;
            rise_pulse <= rise;
            fall_pulse <= fall;
        end
    end

endmodule

// File: rtl/pulse_width_meter.sv
// Measures high time and rise-to-rise period of each complete din cycle and
// delivers results on a valid/ready port, with drop, timeout and overflow status.
module pulse_width_meter
    import pulse_width_meter_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic             edge_rise,
    output logic             edge_fall,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_period,
    output logic             meas_ovf,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             meas_drop,
    output logic             timeout
);

    localparam int unsigned IDLE_W = idle_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [IDLE_W-1:0] IdleLast = IDLE_W'(TIMEOUT - 1);

    logic rise, fall;

    meter_state_t state_q, state_d;
    logic [CNT_W-1:0] hi_q, hi_d, per_q, per_d;
    logic [CNT_W-1:0] hi_inc, per_inc;
    logic ovf_q, ovf_d;
    logic hi_sat, per_sat;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic tmo_q, tmo_d;
    logic complete;

    logic [CNT_W-1:0] res_high_q, res_period_q;
    logic res_ovf_q, valid_q, drop_q;

    edge_detect u_edge_detect (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .rise       (rise),
        .fall       (fall),
        .rise_pulse (edge_rise),
        .fall_pulse (edge_fall)
    );

    assign hi_sat  = (hi_q == CntMax);
    assign per_sat = (per_q == CntMax);
    assign hi_inc  = hi_sat ? hi_q : hi_q + CNT_W'(1);
    assign per_inc = per_sat ? per_q : per_q + CNT_W'(1);

    // Next-state, counter and idle-timer logic.
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        per_d    = per_q;
        ovf_d    = ovf_q;
        idle_d   = idle_q;
        tmo_d    = 1'b0;
        complete = 1'b0;

        unique case (state_q)
            WaitRise: begin
                if (rise) begin
                    state_d = MeasHigh;
                    hi_d    = CNT_W'(1);
                    per_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                end
            end
            MeasHigh: begin
                if (fall) begin
                    state_d = MeasLow;
                    per_d   = per_inc;
                    ovf_d   = ovf_q | per_sat;
                end else begin
                    hi_d  = hi_inc;
                    per_d = per_inc;
                    ovf_d = ovf_q | hi_sat | per_sat;
                end
            end
            MeasLow: begin
                if (rise) begin
                    complete = 1'b1;
                    state_d  = MeasHigh;
                    hi_d     = CNT_W'(1);
                    per_d    = CNT_W'(1);
                    ovf_d    = 1'b0;
                end else begin
                    per_d = per_inc;
                    ovf_d = ovf_q | per_sat;
                end
            end
            default: state_d = WaitRise;
        endcase

        // Any edge restarts the idle timer, so an edge always beats a timeout.
        if (rise || fall) begin
            idle_d = '0;
        end else if (idle_q == IdleLast) begin
            idle_d  = '0;
            tmo_d   = 1'b1;
            state_d = WaitRise;
        end else begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    // FSM, counter and idle-timer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WaitRise;
            hi_q    <= '0;
            per_q   <= '0;
            ovf_q   <= 1'b0;
            idle_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            per_q   <= per_d;
            ovf_q   <= ovf_d;
            idle_q  <= idle_d;
            tmo_q   <= tmo_d;
        end
    end

    // Result register and valid/ready handshake; a held result is never overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_high_q   <= '0;
            res_period_q <= '0;
            res_ovf_q    <= 1'b0;
            valid_q      <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            if (complete && (!valid_q || meas_ready)) begin
                res_high_q   <= hi_q;
                res_period_q <= per_q;
                res_ovf_q    <= ovf_q;
                valid_q      <= 1'b1;
            end else begin
                if (complete) begin
                    drop_q <= 1'b1;
                end
                if (valid_q && meas_ready) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign meas_high   = res_high_q;
    assign meas_period = res_period_q;
    assign meas_ovf    = res_ovf_q;
    assign meas_valid  = valid_q;
    assign meas_drop   = drop_q;
    assign timeout     = tmo_q;

endmodule
